// File: rtl/adc_scan_sequencer.sv
// Round-robin scan sequencer for an 8-channel 12-bit SPI ADC (ADC128S022-style).
// Each frame sends the next channel address and returns the previous frame's conversion.
module adc_scan_sequencer #(
    parameter int SCK_HALF   = 25,
    parameter int GAP_CYCLES = 50
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic        dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        din,
    output logic        res_valid,
    output logic [2:0]  res_chan,
    output logic [11:0] res_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4
    } state_t;

    localparam logic [9:0] HALF_LAST = 10'(SCK_HALF - 1);
    localparam logic [9:0] GAP_LAST  = 10'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;      // 0: SCK low half, 1: SCK high half
    logic [4:0]  bit_q, bit_d;          // SCK period index 1..16
    logic [2:0]  cur_chan_q, cur_chan_d;
    logic [2:0]  prev_chan_q, prev_chan_d;
    logic        prime_q, prime_d;
    logic [11:0] shift_q, shift_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        din_q, din_d;
    logic        res_valid_q, res_valid_d;
    logic [2:0]  res_chan_q, res_chan_d;
    logic [11:0] res_data_q, res_data_d;
    logic        busy_q, busy_d;

    logic        go;
    logic [2:0]  next_chan;

    assign go = enable && (chan_mask != 8'd0);

    // First set mask bit strictly after cur_chan, wrapping; i=8 lands back on cur_chan.
    always_comb begin
        next_chan = cur_chan_q;
        for (int i = 8; i >= 1; i--) begin
            if (chan_mask[cur_chan_q + 3'(i)]) begin
                next_chan = cur_chan_q + 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 10'd1;
        phase_d     = phase_q;
        bit_d       = bit_q;
        cur_chan_d  = cur_chan_q;
        prev_chan_d = prev_chan_q;
        prime_d     = prime_q;
        shift_d     = shift_q;
        res_valid_d = 1'b0;
        res_chan_d  = res_chan_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                cnt_d = 10'd0;
                if (go) begin
                    state_d     = CS_SETUP;
                    prev_chan_d = cur_chan_q;
                    cur_chan_d  = next_chan;
                    prime_d     = 1'b1;
                end
            end
            CS_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 10'd0;
                    state_d = SHIFT;
                    phase_d = 1'b0;
                    bit_d   = 5'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 10'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        // Conversion bits arrive in periods 5..16, MSB first.
                        if (bit_q >= 5'd5) begin
                            shift_d = {shift_q[10:0], dout};
                        end
                    end else if (bit_q == 5'd16) begin
                        state_d = CS_HOLD;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        phase_d = 1'b0;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 10'd0;
                    state_d = GAP;
                    prime_d = 1'b0;
                    // Data just shifted belongs to the address sent one frame earlier.
                    if (!prime_q) begin
                        res_valid_d = 1'b1;
                        res_chan_d  = prev_chan_q;
                        res_data_d  = shift_q;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 10'd0;
                    if (go) begin
                        state_d     = CS_SETUP;
                        prev_chan_d = cur_chan_q;
                        cur_chan_d  = next_chan;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 10'd0;
            end
        endcase
    end

    // Pin values are derived from the next state so every output leaves a flop.
    always_comb begin
        cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
        sck_d  = !((state_d == SHIFT) && !phase_d);
        busy_d = (state_d != IDLE);
        din_d  = 1'b0;
        if (state_d == SHIFT) begin
            case (bit_d)
                5'd3:    din_d = cur_chan_q[2];
                5'd4:    din_d = cur_chan_q[1];
                5'd5:    din_d = cur_chan_q[0];
                default: din_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 10'd0;
            phase_q     <= 1'b0;
            bit_q       <= 5'd0;
            cur_chan_q  <= 3'd7;
            prev_chan_q <= 3'd0;
            prime_q     <= 1'b1;
            shift_q     <= 12'd0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b1;
            din_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_chan_q  <= 3'd0;
            res_data_q  <= 12'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            cur_chan_q  <= cur_chan_d;
            prev_chan_q <= prev_chan_d;
            prime_q     <= prime_d;
            shift_q     <= shift_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            din_q       <= din_d;
            res_valid_q <= res_valid_d;
            res_chan_q  <= res_chan_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign adc_cs_n  = cs_n_q;
    assign adc_sck   = sck_q;
    assign din       = din_q;
    assign res_valid = res_valid_q;
    assign res_chan  = res_chan_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC that answers
// each frame with the value of the channel addressed in the previous frame.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

    logic        clk_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  chan_mask = 8'h00;
    logic        dout = 1'b0;
    wire         adc_cs_n, adc_sck, din, res_valid, busy;
    wire  [2:0]  res_chan;
    wire  [11:0] res_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [11:0] chan_val [8];
    logic [2:0]  r_chan [$];
    logic [11:0] r_data [$];
    int          r_cyc [$];
    logic [2:0]  a_log [$];

    int          sck_k = 0;
    logic [2:0]  addr_sr = 3'd0;
    logic [2:0]  next_addr = 3'd0;
    logic [2:0]  out_addr = 3'd0;

    adc_scan_sequencer dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .enable    (enable),
        .chan_mask (chan_mask),
        .dout      (dout),
        .adc_cs_n  (adc_cs_n),
        .adc_sck   (adc_sck),
        .din       (din),
        .res_valid (res_valid),
        .res_chan  (res_chan),
        .res_data  (res_data),
        .busy      (busy)
    );

    // clock / cycle counter
    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // result monitor
    always @(negedge clk_50) begin
        if (res_valid === 1'b1) begin
            r_chan.push_back(res_chan);
            r_data.push_back(res_data);
            r_cyc.push_back(cyc);
        end
    end

    // ADC model
    always @(negedge adc_cs_n) begin
        sck_k = 0;
        out_addr = next_addr;
    end

    always @(negedge adc_sck) begin
        if (adc_cs_n === 1'b0) begin
            sck_k = sck_k + 1;
            if (sck_k >= 5 && sck_k <= 16) dout = chan_val[out_addr][16 - sck_k];
            else dout = 1'b0;
        end
    end

    always @(posedge adc_sck) begin
        if (adc_cs_n === 1'b0 && sck_k >= 3 && sck_k <= 5) begin
            addr_sr = {addr_sr[1:0], din};
            if (sck_k == 5) begin
                next_addr = addr_sr;
                a_log.push_back(addr_sr);
            end
        end
    end

    // driver tasks
    task automatic clear_logs();
        r_chan.delete();
        r_data.delete();
        r_cyc.delete();
        a_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        chan_mask = 8'h00;
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        @(negedge clk_50);
        clear_logs();
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int t = 0;
        while (r_chan.size() < n && t < budget) begin
            @(negedge clk_50);
            t++;
        end
        checks++;
        if (r_chan.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: strobes=%0d required=%0d", tag, r_chan.size(), n);
        end
    endtask

    task automatic wait_bit(input int k, input string tag);
        int t = 0;
        while (!(adc_cs_n === 1'b0 && sck_k == k) && t < 2000) begin
            @(negedge clk_50);
            t++;
        end
        checks++;
        if (!(adc_cs_n === 1'b0 && sck_k == k)) begin
            failures++;
            $display("FAIL %s_bit_timeout: sck_k=%0d required=%0d", tag, sck_k, k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b exp 1", adc_cs_n); end
        checks++; if (adc_sck !== 1'b1) begin failures++; $display("FAIL reset_sck: got %b exp 1", adc_sck); end
        checks++; if (din !== 1'b0) begin failures++; $display("FAIL reset_din: got %b exp 0", din); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
        checks++; if (res_chan !== 3'd0) begin failures++; $display("FAIL reset_res_chan: got %0d exp 0", res_chan); end
        checks++; if (res_data !== 12'd0) begin failures++; $display("FAIL reset_res_data: got %h exp 000", res_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_single_channel();
        int c0, t1, t2;
        do_reset();
        chan_val[5] = 12'hABC;
        @(negedge clk_50);
        chan_mask = 8'h20;
        enable = 1'b1;
        c0 = cyc;
        wait_bit(2, "single");
        t1 = cyc;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b exp 1", busy); end
        wait_bit(3, "single");
        t2 = cyc;
        checks++; if (t2 - t1 !== 50) begin failures++; $display("FAIL single_sck_period: got %0d exp 50", t2 - t1); end
        wait_strobes(3, 4000, "single");
        checks++; if (a_log[0] !== 3'd5) begin failures++; $display("FAIL single_addr: got %0d exp 5", a_log[0]); end
        checks++; if (r_cyc[0] - c0 !== 1751) begin failures++; $display("FAIL single_first_strobe: got %0d exp 1751", r_cyc[0] - c0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (r_chan[i] !== 3'd5) begin failures++; $display("FAIL single_chan%0d: got %0d exp 5", i, r_chan[i]); end
            checks++; if (r_data[i] !== 12'hABC) begin failures++; $display("FAIL single_data%0d: got %h exp abc", i, r_data[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            checks++; if (r_cyc[i] - r_cyc[i-1] !== 900) begin failures++; $display("FAIL single_spacing%0d: got %0d exp 900", i, r_cyc[i] - r_cyc[i-1]); end
        end
    endtask

    task automatic test_three_channels();
        logic [2:0]  exp_c [4];
        logic [11:0] exp_d [4];
        exp_c = '{3'd5, 3'd6, 3'd7, 3'd5};
        exp_d = '{12'h100, 12'h800, 12'hFFF, 12'h100};
        do_reset();
        chan_val[5] = 12'h100;
        chan_val[6] = 12'h800;
        chan_val[7] = 12'hFFF;
        @(negedge clk_50);
        chan_mask = 8'hE0;
        enable = 1'b1;
        wait_strobes(4, 5000, "three");
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_log[i] !== exp_c[i]) begin failures++; $display("FAIL three_addr%0d: got %0d exp %0d", i, a_log[i], exp_c[i]); end
            checks++; if (r_chan[i] !== exp_c[i]) begin failures++; $display("FAIL three_chan%0d: got %0d exp %0d", i, r_chan[i], exp_c[i]); end
            checks++; if (r_data[i] !== exp_d[i]) begin failures++; $display("FAIL three_data%0d: got %h exp %h", i, r_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [2:0]  exp_a [4];
        logic [11:0] exp_d [3];
        exp_a = '{3'd0, 3'd7, 3'd0, 3'd7};
        exp_d = '{12'h5A5, 12'h3C3, 12'h5A5};
        do_reset();
        chan_val[0] = 12'h5A5;
        chan_val[7] = 12'h3C3;
        @(negedge clk_50);
        chan_mask = 8'h81;
        enable = 1'b1;
        wait_strobes(3, 4000, "wrap");
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_log[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr%0d: got %0d exp %0d", i, a_log[i], exp_a[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (r_chan[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_chan%0d: got %0d exp %0d", i, r_chan[i], exp_a[i]); end
            checks++; if (r_data[i] !== exp_d[i]) begin failures++; $display("FAIL wrap_data%0d: got %h exp %h", i, r_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_enable_drop();
        int t, c0;
        do_reset();
        chan_val[5] = 12'hABC;
        @(negedge clk_50);
        chan_mask = 8'h20;
        enable = 1'b1;
        wait_strobes(1, 2500, "drop");
        wait_bit(8, "drop");
        enable = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 2000) begin
            @(negedge clk_50);
            t++;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy: got %b exp 0", busy); end
        checks++; if (r_chan.size() !== 2) begin failures++; $display("FAIL drop_strobe_count: got %0d exp 2", r_chan.size()); end
        checks++; if (r_data[1] !== 12'hABC) begin failures++; $display("FAIL drop_last_data: got %h exp abc", r_data[1]); end
        checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL drop_cs_n: got %b exp 1", adc_cs_n); end
        checks++; if (adc_sck !== 1'b1) begin failures++; $display("FAIL drop_sck: got %b exp 1", adc_sck); end
        repeat (1000) @(negedge clk_50);
        checks++; if (a_log.size() !== 3) begin failures++; $display("FAIL drop_frames: got %0d exp 3", a_log.size()); end
        checks++; if (res_chan !== 3'd5) begin failures++; $display("FAIL drop_hold_chan: got %0d exp 5", res_chan); end
        checks++; if (res_data !== 12'hABC) begin failures++; $display("FAIL drop_hold_data: got %h exp abc", res_data); end
        clear_logs();
        enable = 1'b1;
        c0 = cyc;
        wait_strobes(1, 2500, "reenable");
        checks++; if (r_cyc[0] - c0 !== 1751) begin failures++; $display("FAIL reenable_first_strobe: got %0d exp 1751", r_cyc[0] - c0); end
        checks++; if (r_chan[0] !== 3'd5) begin failures++; $display("FAIL reenable_chan: got %0d exp 5", r_chan[0]); end
    endtask

    task automatic test_reset_mid_shift();
        int c0;
        do_reset();
        chan_val[4] = 12'h777;
        @(negedge clk_50);
        chan_mask = 8'h10;
        enable = 1'b1;
        wait_strobes(1, 2500, "midrst");
        wait_bit(3, "midrst");
        checks++; if (din !== 1'b1) begin failures++; $display("FAIL midrst_add2: got %b exp 1", din); end
        rst_n = 1'b0;
        #1;
        checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL midrst_cs_n: got %b exp 1", adc_cs_n); end
        checks++; if (adc_sck !== 1'b1) begin failures++; $display("FAIL midrst_sck: got %b exp 1", adc_sck); end
        checks++; if (din !== 1'b0) begin failures++; $display("FAIL midrst_din: got %b exp 0", din); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midrst_res_valid: got %b exp 0", res_valid); end
        checks++; if (res_data !== 12'd0) begin failures++; $display("FAIL midrst_res_data: got %h exp 000", res_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b exp 0", busy); end
        @(negedge clk_50);
        clear_logs();
        rst_n = 1'b1;
        c0 = cyc;
        wait_strobes(1, 2500, "midrst_restart");
        checks++; if (r_cyc[0] - c0 !== 1751) begin failures++; $display("FAIL midrst_first_strobe: got %0d exp 1751", r_cyc[0] - c0); end
        checks++; if (r_chan[0] !== 3'd4) begin failures++; $display("FAIL midrst_chan: got %0d exp 4", r_chan[0]); end
        checks++; if (r_data[0] !== 12'h777) begin failures++; $display("FAIL midrst_data: got %h exp 777", r_data[0]); end
    endtask

    task automatic test_mask_change();
        do_reset();
        chan_val[0] = 12'h0F0;
        chan_val[4] = 12'h444;
        @(negedge clk_50);
        chan_mask = 8'h01;
        enable = 1'b1;
        wait_strobes(1, 2500, "mask");
        wait_bit(8, "mask");
        chan_mask = 8'h10;
        wait_strobes(4, 4000, "mask");
        checks++; if (a_log[2] !== 3'd0) begin failures++; $display("FAIL mask_addr_cur: got %0d exp 0", a_log[2]); end
        checks++; if (a_log[3] !== 3'd4) begin failures++; $display("FAIL mask_addr_next: got %0d exp 4", a_log[3]); end
        checks++; if (r_chan[2] !== 3'd0) begin failures++; $display("FAIL mask_chan2: got %0d exp 0", r_chan[2]); end
        checks++; if (r_data[2] !== 12'h0F0) begin failures++; $display("FAIL mask_data2: got %h exp 0f0", r_data[2]); end
        checks++; if (r_chan[3] !== 3'd4) begin failures++; $display("FAIL mask_chan3: got %0d exp 4", r_chan[3]); end
        checks++; if (r_data[3] !== 12'h444) begin failures++; $display("FAIL mask_data3: got %h exp 444", r_data[3]); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_three_channels();
        test_wrap();
        test_enable_drop();
        test_reset_mid_shift();
        test_mask_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
